// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit 5-stage RISC core.
// Pipeline sequencer states, opcode encodings and default register address width.
package cpu_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   localparam logic [2:0] OP_RTYPE = 3'b000;
   localparam logic [2:0] OP_LW    = 3'b001;
   localparam logic [2:0] OP_SW    = 3'b010;
   localparam logic [2:0] OP_BEQ   = 3'b011;
   localparam logic [2:0] OP_J     = 3'b100;

   localparam int REG_AW_DEFAULT = 2;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently sitting in EX.
module hazard_detect
   import cpu_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEFAULT
) (
   input  logic                   id_valid,
   input  logic [1:0][REG_AW-1:0] src_reg,
   input  logic [1:0]             src_used,
   input  logic                   ex_valid,
   input  logic                   ex_mem_read,
   input  logic [REG_AW-1:0]      ex_rd,
   output logic                   load_use
);

   logic [1:0] src_hit;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         assign src_hit[gi] = src_used[gi] && (src_reg[gi] == ex_rd);
      end
   endgenerate

   assign load_use = ex_valid && ex_mem_read && id_valid && (|src_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: per-stage enable/flush/bubble generation with load-use
// stall, branch/jump flush, dmem wait-state handshake with timeout, stall counter.
module pipe_hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int REG_AW      = REG_AW_DEFAULT,
   parameter int TO_W        = 4,
   parameter int MEM_TIMEOUT = 12,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              id_jump,
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_branch_taken,
   input  logic              mem_valid,
   input  logic              mem_access,
   input  logic              dmem_ready,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output logic              idex_en,
   output logic              exmem_en,
   output logic              memwb_bubble,
   output logic              dmem_req,
   output logic              mem_err,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [1:0]        state_o
);

   state_t           state_q, state_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q;

   logic load_use;
   logic mem_stall;
   logic eval_hazards;

   hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
      .id_valid    (id_valid),
      .src_reg     ({id_rt, id_rs}),
      .src_used    ({id_uses_rt, id_uses_rs}),
      .ex_valid    (ex_valid),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .load_use    (load_use)
   );

   assign mem_stall = mem_valid && mem_access && !dmem_ready;

   always_comb begin
      state_d      = state_q;
      to_d         = to_q;
      err_d        = err_q;
      eval_hazards = 1'b0;
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      memwb_bubble = 1'b0;
      dmem_req     = mem_valid && mem_access;

      case (state_q)
         RUN: begin
            if (mem_stall) begin
               // Upstream is frozen, so any branch/load-use waits for release.
               pc_en        = 1'b0;
               ifid_en      = 1'b0;
               idex_en      = 1'b0;
               exmem_en     = 1'b0;
               memwb_bubble = 1'b1;
               dmem_req     = 1'b1;
               state_d      = MEM_WAIT;
               to_d         = TO_W'(1);
            end else begin
               eval_hazards = 1'b1;
            end
         end
         MEM_WAIT: begin
            dmem_req = 1'b1;
            if (dmem_ready) begin
               state_d = RUN;
               to_d    = '0;
            end else begin
               pc_en        = 1'b0;
               ifid_en      = 1'b0;
               idex_en      = 1'b0;
               exmem_en     = 1'b0;
               memwb_bubble = 1'b1;
               if (to_q == TO_W'(MEM_TIMEOUT)) begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end else begin
                  to_d = to_q + TO_W'(1);
               end
            end
         end
         default: begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            dmem_req     = 1'b0;
         end
      endcase

      if (eval_hazards) begin
         if (ex_branch_taken && ex_valid) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
         end else if (id_jump && id_valid) begin
            ifid_flush = 1'b1;
         end
      end

      if (reset) begin
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         exmem_en     = 1'b0;
         ifid_flush   = 1'b1;
         idex_bubble  = 1'b1;
         memwb_bubble = 1'b1;
         dmem_req     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         to_q    <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         to_q    <= to_d;
         err_q   <= err_d;
         if (!pc_en && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign mem_err   = err_q;
   assign stall_cnt = cnt_q;
   assign state_o   = state_q;

endmodule
